// File: rtl/lzc_pipe.sv
// Pipelined leading-zero / leading-one counter with valid/ready handshakes on both sides.
// Define LZC_PIPE_NORM_EN to add o_norm (operand shifted left by the count, carried alongside o_cnt).
module lzc_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    localparam int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNTW-1:0]  o_cnt,
    output logic             o_sat
`ifdef LZC_PIPE_NORM_EN
    ,
    output logic [WIDTH-1:0] o_norm
`endif
);

    localparam int LVLS = $clog2(WIDTH);
    localparam int PADW = 1 << LVLS;

    // Merge level j+1 is built in stage mergeStage(j); the root merge always lands in the last stage,
    // and each earlier stage registers the tree right after the last level it builds.
    function automatic int mergeStage(input int j);
        return ((j + 1) * STAGES - 1) / LVLS;
    endfunction

    function automatic int endLevel(input int k);
        int n;
        n = 0;
        for (int j = 0; j < LVLS; j++)
            if (mergeStage(j) <= k) n++;
        return n;
    endfunction

    function automatic int regStage(input int l);
        int s;
        s = -1;
        for (int k = 0; k < STAGES - 1; k++)
            if (endLevel(k) == l) s = k;
        return s;
    endfunction

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] validIn;
    logic [STAGES-1:0] rdy;
    logic              allFull;
    logic [PADW-1:0]   padded;
    logic [CNTW-1:0]   cnt_d, cnt_q;
    logic              sat_d, sat_q;

    // A stage may load unless it and every stage after it are full while the output is stalled.
    always_comb begin
        allFull = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            allFull = allFull & valid_q[k];
            rdy[k]  = i_ready | ~allFull;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_vin
        if (k == 0) begin : g_first
            assign validIn[k] = i_valid;
        end else begin : g_next
            assign validIn[k] = valid_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (rdy[k]) valid_q[k] <= validIn[k];
        end
    end

    // Leading ones become leading zeros of the inverted operand; padding below the LSB is always a stopper.
    always_comb begin
        padded = '1;
        padded[PADW-1 -: WIDTH] = i_data ^ {WIDTH{i_mode}};
    end

    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        localparam int N  = PADW >> l;
        localparam int RS = regStage(l);

        logic [N-1:0]           zC, zO;
        logic [N-1:0][CNTW-1:0] cntC, cntO;

        if (l == 0) begin : g_leaf
            assign zC   = ~padded;
            assign cntC = '0;
        end else begin : g_merge
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    if (g_lvl[l-1].zO[2*i+1]) begin
                        zC[i]   = g_lvl[l-1].zO[2*i];
                        cntC[i] = g_lvl[l-1].cntO[2*i] | CNTW'(1 << (l - 1));
                    end else begin
                        zC[i]   = 1'b0;
                        cntC[i] = g_lvl[l-1].cntO[2*i+1];
                    end
                end
            end
        end

        if (RS >= 0) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    zO   <= '0;
                    cntO <= '0;
                end else if (rdy[RS]) begin
                    zO   <= zC;
                    cntO <= cntC;
                end
            end
        end else begin : g_wire
            assign zO   = zC;
            assign cntO = cntC;
        end
    end

    always_comb begin
        cnt_d = g_lvl[LVLS].zO[0] ? CNTW'(PADW) : g_lvl[LVLS].cntO[0];
        sat_d = (cnt_d == CNTW'(WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (rdy[STAGES-1]) begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign o_ready = rdy[0];
    assign o_valid = valid_q[STAGES-1];
    assign o_cnt   = o_valid ? cnt_q : '0;
    assign o_sat   = o_valid & sat_q;

`ifdef LZC_PIPE_NORM_EN
    logic [WIDTH-1:0] dataLast;
    logic [WIDTH-1:0] norm_d, norm_q;

    for (genvar k = 0; k < STAGES - 1; k++) begin : g_data
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] dataIn;
        if (k == 0) begin : g_first
            assign dataIn = i_data;
        end else begin : g_next
            assign dataIn = g_data[k-1].data_q;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) data_q <= '0;
            else if (rdy[k]) data_q <= dataIn;
        end
    end

    if (STAGES == 1) begin : g_dlast_in
        assign dataLast = i_data;
    end else begin : g_dlast_reg
        assign dataLast = g_data[STAGES-2].data_q;
    end

    // A count of WIDTH shifts every bit out, which gives the required all-zero result.
    assign norm_d = dataLast << cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) norm_q <= '0;
        else if (rdy[STAGES-1]) norm_q <= norm_d;
    end

    assign o_norm = o_valid ? norm_q : '0;
`endif

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed bench for lzc_pipe: a 16-bit/2-stage instance and a 13-bit/3-stage instance.
// Define LZC_PIPE_NORM_EN to also check o_norm on the 16-bit instance.
module tb_lzc_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        aValid, aReady, aMode, aOutValid, aInReady, aSat;
    logic [15:0] aData;
    logic [4:0]  aCnt;
    logic        bValid, bReady, bMode, bOutValid, bInReady, bSat;
    logic [12:0] bData;
    logic [4:0]  bCnt;
`ifdef LZC_PIPE_NORM_EN
    logic [15:0] aNorm;
    logic [12:0] bNorm;
`endif

    lzc_pipe #(.WIDTH(16), .STAGES(2)) dutA (
        .clk(clk), .rst(rst), .i_valid(aValid), .o_ready(aReady), .i_data(aData), .i_mode(aMode),
        .o_valid(aOutValid), .i_ready(aInReady), .o_cnt(aCnt), .o_sat(aSat)
`ifdef LZC_PIPE_NORM_EN
        , .o_norm(aNorm)
`endif
    );

    lzc_pipe #(.WIDTH(13), .STAGES(3)) dutB (
        .clk(clk), .rst(rst), .i_valid(bValid), .o_ready(bReady), .i_data(bData), .i_mode(bMode),
        .o_valid(bOutValid), .i_ready(bInReady), .o_cnt(bCnt), .o_sat(bSat)
`ifdef LZC_PIPE_NORM_EN
        , .o_norm(bNorm)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] vData [8];
    logic        vMode [8];
    int          vCnt  [8];
    logic        vSat  [8];
    logic [15:0] vNorm [8];

    int bpReady [12] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int bpValid [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int bpCnt   [12] = '{0, 0, 1, 1, 1, 1, 1, 2, 3, 4, 5, 0};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setVec(input int i, input logic [15:0] d, input logic m, input int c, input logic s,
                          input logic [15:0] nrm);
        vData[i] = d;
        vMode[i] = m;
        vCnt[i]  = c;
        vSat[i]  = s;
        vNorm[i] = nrm;
    endtask

    // Streams n vectors back-to-back into DUT sel (0 = 16/2, 1 = 13/3) and checks each
    // result exactly STAGES cycles after it was presented.
    task automatic applyStimulus(input int sel, input int n);
        int stg;
        int idx;
        logic       oV, oS;
        logic [4:0] oC;
        stg = (sel == 0) ? 2 : 3;
        for (int t = 0; t <= n + stg; t++) begin
            @(negedge clk);
            if (sel == 0) begin
                oV = aOutValid; oC = aCnt; oS = aSat;
            end else begin
                oV = bOutValid; oC = bCnt; oS = bSat;
            end
            if (t >= stg && t - stg < n) begin
                idx = t - stg;
                checkOutput($sformatf("s%0d_valid%0d", sel, idx), oV, 1);
                checkOutput($sformatf("s%0d_cnt%0d", sel, idx), oC, vCnt[idx]);
                checkOutput($sformatf("s%0d_sat%0d", sel, idx), oS, vSat[idx]);
`ifdef LZC_PIPE_NORM_EN
                if (sel == 0) checkOutput($sformatf("s0_norm%0d", idx), aNorm, vNorm[idx]);
`endif
            end else begin
                checkOutput($sformatf("s%0d_idle_valid%0d", sel, t), oV, 0);
                checkOutput($sformatf("s%0d_idle_cnt%0d", sel, t), oC, 0);
`ifdef LZC_PIPE_NORM_EN
                if (sel == 0) checkOutput($sformatf("s0_idle_norm%0d", t), aNorm, 0);
`endif
            end
            if (sel == 0) begin
                aValid = (t < n);
                if (t < n) begin aData = vData[t]; aMode = vMode[t]; end
            end else begin
                bValid = (t < n);
                if (t < n) begin bData = vData[t][12:0]; bMode = vMode[t]; end
            end
        end
    endtask

    initial begin
        int sendIdx;
        rst = 1'b1;
        aValid = 0; aData = '0; aMode = 0; aInReady = 1;
        bValid = 0; bData = '0; bMode = 0; bInReady = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_a_valid", aOutValid, 0);
        checkOutput("rst_a_cnt", aCnt, 0);
        checkOutput("rst_a_sat", aSat, 0);
        checkOutput("rst_a_ready", aReady, 1);
        checkOutput("rst_b_valid", bOutValid, 0);
        checkOutput("rst_b_ready", bReady, 1);

        $display("[TB] leading zeros, 16 bit");
        setVec(0, 16'h8000, 0, 0, 0, 16'h8000);
        setVec(1, 16'h0001, 0, 15, 0, 16'h8000);
        setVec(2, 16'h0000, 0, 16, 1, 16'h0000);
        applyStimulus(0, 3);

        $display("[TB] leading ones and mixed modes, 16 bit");
        setVec(0, 16'hFFF0, 1, 12, 0, 16'h0000);
        setVec(1, 16'hFFFF, 1, 16, 1, 16'h0000);
        setVec(2, 16'hFFF0, 0, 0, 0, 16'hFFF0);
        setVec(3, 16'h00F3, 0, 8, 0, 16'hF300);
        setVec(4, 16'h0000, 0, 16, 1, 16'h0000);
        setVec(5, 16'h0000, 1, 0, 0, 16'h0000);
        applyStimulus(0, 6);

        $display("[TB] 13 bit, 3 stages");
        setVec(0, 16'h0001, 0, 12, 0, 16'h0000);
        setVec(1, 16'h1000, 0, 0, 0, 16'h0000);
        setVec(2, 16'h0000, 0, 13, 1, 16'h0000);
        setVec(3, 16'h1FFE, 1, 12, 0, 16'h0000);
        setVec(4, 16'h1FFF, 1, 13, 1, 16'h0000);
        applyStimulus(1, 5);

        $display("[TB] backpressure");
        sendIdx = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_valid%0d", t), aOutValid, bpValid[t]);
            checkOutput($sformatf("bp_cnt%0d", t), aCnt, bpCnt[t]);
            aInReady = bpReady[t][0];
            aMode = 0;
            if (sendIdx < 5) begin
                aValid = 1;
                aData = 16'h4000 >> sendIdx;
            end else begin
                aValid = 0;
            end
            #1;
            checkOutput($sformatf("bp_ready%0d", t), aReady, bpReady[t]);
            if (aValid && aReady) sendIdx++;
        end
        checkOutput("bp_sent", sendIdx, 5);
        aValid = 0;
        aInReady = 1;

        $display("[TB] reset with operands in flight");
        aInReady = 0;
        @(negedge clk);
        aValid = 1; aData = 16'h0000;
        @(negedge clk);
        aData = 16'h0003;
        @(negedge clk);
        aValid = 0;
        checkOutput("rst_inflight_valid", aOutValid, 1);
        checkOutput("rst_inflight_ready", aReady, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", aOutValid, 0);
        checkOutput("rst_async_cnt", aCnt, 0);
        checkOutput("rst_async_sat", aSat, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_release_ready", aReady, 1);
        aInReady = 1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_flush%0d", t), aOutValid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lzc_pipe.md
Name: lzc_pipe

Overview:
Pipelined, parametrised leading-bit counter with valid/ready handshakes on both sides.
- Counts leading zeros (mode 0) or leading ones (mode 1) of a WIDTH-bit operand; mode is selectable per transaction.
- Flags an operand made entirely of the counted bit.
- Sits in front of normalisation and priority logic where the combinational counter no longer closes timing at wide widths.

Parameters:
- WIDTH, 16, operand width; any value >= 2, power of two not required.
- STAGES, 2, register stages from input to output; legal range 1..$clog2(WIDTH)+1.
- CNTW (localparam), $clog2(WIDTH)+1, width of the count output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  operand valid.
- o_ready  output  1  block can accept an operand this cycle.
- i_data  input  WIDTH  operand; bit WIDTH-1 is the MSB.
- i_mode  input  1  0 = count leading zeros, 1 = count leading ones; sampled with i_data.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_cnt  output  CNTW  count of consecutive bits equal to the counted value, starting at the MSB.
- o_sat  output  1  every operand bit equals the counted value.

Behaviour:
- Reset: one clock, asynchronous, active-high, as already decided.
- Reset values: o_valid=0, o_cnt=0, o_sat=0, all internal stage valids=0. o_ready=1 in the first cycle after rst deasserts.
- Input transfer: i_valid && o_ready at a rising edge. Output transfer: o_valid && i_ready.
- Count definition:
  - o_cnt = number of bits from WIDTH-1 downward that equal i_mode, stopping at the first bit that differs.
  - Range 0..WIDTH. If no bit differs, o_cnt=WIDTH and o_sat=1; otherwise o_sat=0.
  - o_cnt and o_sat are never both inconsistent: o_sat=1 exactly when o_cnt==WIDTH.
- Mode 1 is computed on the inverted operand using the same datapath as mode 0.
- Non-power-of-2 WIDTH: pad internally below the LSB with the complement of i_mode, so padding never extends the count.
- Datapath partitioning:
  - Split into STAGES register stages: tree levels are distributed evenly, with the final merge in the last stage.
  - Any partition is acceptable provided results match the count definition bit-exactly.
- Latency: exactly STAGES cycles from input transfer to o_valid when i_ready is held high.
- Throughput: one transfer per cycle with i_ready=1.
- Stage flow control (per-stage valid, bubble-collapsing):
  - Stage k loads when it is empty or when its contents move to stage k+1 in the same cycle.
  - o_ready = ~v0 | advance0. It may depend combinationally on i_ready.
  - Gaps in i_valid must not cost throughput once the pipe refills.
- Backpressure: while o_valid && !i_ready, o_cnt and o_sat hold stable. Upstream stages keep filling until full, then o_ready deasserts.
- Ordering: results leave strictly in input order; no drops, no duplicates.
- Simultaneous input and output transfer on a full pipe: both complete with no bubble.
- Reset mid-operation: all in-flight operands are discarded and no result is emitted for them. Outputs take reset values immediately (asynchronously).
- Unused or invalid stage contents: don't-care internally. o_cnt and o_sat must read 0 whenever o_valid=0.

Optional Feature:
- Macro: LZC_PIPE_NORM_EN.
- Defined:
  - Adds output port o_norm (WIDTH bits) = i_data shifted left by o_cnt, zero-filled; o_norm=0 when o_cnt==WIDTH.
  - o_norm is carried through the pipeline aligned with o_cnt, follows the same hold rules, and reads 0 when o_valid=0.
  - The shift may be split across stages but adds no latency.
- Not defined: o_norm and all of its logic and registers are absent; port list as above.

Test Plan:
- WIDTH=16, STAGES=2, i_ready=1, mode 0, inputs 16'h8000, 16'h0001, 16'h0000 back-to-back -> outputs o_cnt=0,15,16 with o_sat=0,0,1 on cycles 2,3,4 after the first transfer.
- Mode 1, inputs 16'hFFF0 and 16'hFFFF -> o_cnt=12 (o_sat=0), then o_cnt=16 (o_sat=1); mixed-mode stream 16'hFFF0 mode 0 -> o_cnt=0.
- Backpressure: 5 back-to-back inputs, i_ready low for 4 cycles after the first o_valid -> o_ready drops once STAGES+... stages are full, o_cnt stays constant while stalled, all 5 results exit in order.
- WIDTH=13, STAGES=3: inputs 13'h0001 -> 12; 13'h1000 -> 0; 13'h0000 -> 13 with o_sat=1; mode 1 13'h1FFE -> 12.
- Assert rst while 2 operands are in flight -> o_valid=0 immediately, o_ready=1 after release, and neither operand ever appears at the output.
- With LZC_PIPE_NORM_EN: 16'h00F3 mode 0 -> o_cnt=8, o_norm=16'hF300; 16'h0000 -> o_norm=0.
